pc_stack_reg: RTL and testbench

//  Parametrised program-counter register; next generation of the single-width PC/IR register.

---
 rtl/pc_stack_reg.sv | 124 ++++++++++++
 tb/tb_pc_stack_reg.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pc_stack_reg.sv
// Program-counter register with step increment, signed relative branch and an optional
// call/return address stack, enabled by defining PC_CALL_STACK_EN.
module pc_stack_reg #(
    parameter int               W         = 8,
    parameter int               STEP      = 1,
    parameter int               DEPTH     = 4,
    parameter logic [W-1:0]     RESET_VEC = '0
) (
    input  logic         Clk,
    input  logic         RST_n,
    input  logic         RST,
    input  logic         Wen,
    input  logic         INC,
    input  logic         BR,
    input  logic         CALL,
    input  logic         RET,
    input  logic [W-1:0] BusOut,
    output logic [W-1:0] dout,
    output logic         stk_full,
    output logic         stk_empty,
    output logic         stk_err
);

    localparam logic [W-1:0] STEP_W = W'(STEP);

    logic [W-1:0] pc_inc;
    logic [W-1:0] pc_br;

    // Adding the W-bit offset modulo 2^W is the same as adding its sign extension.
    assign pc_inc = dout + STEP_W;
    assign pc_br  = dout + BusOut;

`ifdef PC_CALL_STACK_EN

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          is_full;
    logic          is_empty;
    logic          push;
    logic          err;

    assign is_full  = (ptr == DEPTH_P);
    assign is_empty = (ptr == '0);
    assign wr_idx   = ptr[IW-1:0];
    assign rd_idx   = IW'(ptr - 1'b1);
    assign push     = !RST && !RET && CALL && !is_full;

    // Stack storage is not reset; only the pointer defines validity.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_idx] <= pc_inc;
        end
    end

    always_ff @(posedge Clk or negedge RST_n) begin
        if (!RST_n) begin
            dout <= RESET_VEC;
            ptr  <= '0;
            err  <= 1'b0;
        end else if (RST) begin
            dout <= RESET_VEC;
            ptr  <= '0;
            err  <= 1'b0;
        end else if (RET) begin
            if (is_empty) begin
                err <= 1'b1;
            end else begin
                ptr  <= ptr - 1'b1;
                dout <= mem[rd_idx];
            end
        end else if (CALL) begin
            if (is_full) begin
                err <= 1'b1;
            end else begin
                ptr  <= ptr + 1'b1;
                dout <= BusOut;
            end
        end else if (BR) begin
            dout <= pc_br;
        end else if (Wen) begin
            dout <= BusOut;
        end else if (INC) begin
            dout <= pc_inc;
        end
    end

    assign stk_full  = is_full;
    assign stk_empty = is_empty;
    assign stk_err   = err;

`else

    // Without a stack, CALL is a plain load and RET keeps its priority slot as a hold.
    always_ff @(posedge Clk or negedge RST_n) begin
        if (!RST_n) begin
            dout <= RESET_VEC;
        end else if (RST) begin
            dout <= RESET_VEC;
        end else if (RET) begin
            dout <= dout;
        end else if (CALL) begin
            dout <= BusOut;
        end else if (BR) begin
            dout <= pc_br;
        end else if (Wen) begin
            dout <= BusOut;
        end else if (INC) begin
            dout <= pc_inc;
        end
    end

    assign stk_full  = 1'b0;
    assign stk_empty = 1'b1;
    assign stk_err   = 1'b0;

`endif

endmodule

// File: tb/tb_pc_stack_reg.sv
// Directed self-checking bench for pc_stack_reg (W=8, STEP=1, DEPTH=4, RESET_VEC=0).
module tb_pc_stack_reg;

    logic       Clk = 1'b0;
    logic       RST_n = 1'b0;
    logic       RST = 1'b0;
    logic       Wen = 1'b0;
    logic       INC = 1'b0;
    logic       BR = 1'b0;
    logic       CALL = 1'b0;
    logic       RET = 1'b0;
    logic [7:0] BusOut = 8'h00;
    logic [7:0] dout;
    logic       stk_full;
    logic       stk_empty;
    logic       stk_err;

    int passed = 0;
    int total  = 0;

    pc_stack_reg #(.W(8), .STEP(1), .DEPTH(4), .RESET_VEC(8'h00)) dut (
        .Clk(Clk), .RST_n(RST_n), .RST(RST), .Wen(Wen), .INC(INC), .BR(BR),
        .CALL(CALL), .RET(RET), .BusOut(BusOut), .dout(dout),
        .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
    );

    always #5 Clk = ~Clk;

    // Apply the currently driven strobes for one edge, then release them.
    task automatic step();
        @(posedge Clk);
        #1;
        RST = 0; Wen = 0; INC = 0; BR = 0; CALL = 0; RET = 0;
    endtask

    task automatic load(input logic [7:0] v);
        Wen = 1; BusOut = v;
        step();
    endtask

    task automatic test_reset();
        #3;
        total++; if (dout !== 8'h00) $display("FAIL reset_dout got=%h exp=00", dout); else passed++;
        total++; if (stk_empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", stk_empty); else passed++;
        total++; if (stk_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", stk_full); else passed++;
        total++; if (stk_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", stk_err); else passed++;
        @(negedge Clk);
        RST_n = 1;
        @(posedge Clk); #1;
        load(8'h55);
        total++; if (dout !== 8'h55) $display("FAIL load_55 got=%h exp=55", dout); else passed++;
        RST_n = 0;
        #1;
        total++; if (dout !== 8'h00) $display("FAIL async_reset_dout got=%h exp=00", dout); else passed++;
        total++; if (stk_empty !== 1'b1) $display("FAIL async_reset_empty got=%b exp=1", stk_empty); else passed++;
        @(negedge Clk);
        RST_n = 1;
        @(posedge Clk); #1;
    endtask

    task automatic test_inc();
        load(8'hFF);
        INC = 1; step();
        total++; if (dout !== 8'h00) $display("FAIL inc_wrap got=%h exp=00", dout); else passed++;
        INC = 1; step();
        total++; if (dout !== 8'h01) $display("FAIL inc_01 got=%h exp=01", dout); else passed++;
        step();
        total++; if (dout !== 8'h01) $display("FAIL hold got=%h exp=01", dout); else passed++;
    endtask

    task automatic test_branch();
        load(8'h02);
        BR = 1; BusOut = 8'hFC; step();
        total++; if (dout !== 8'hFE) $display("FAIL br_back got=%h exp=FE", dout); else passed++;
        BR = 1; BusOut = 8'h05; step();
        total++; if (dout !== 8'h03) $display("FAIL br_fwd_wrap got=%h exp=03", dout); else passed++;
    endtask

    task automatic test_priority();
        load(8'h20);
        Wen = 1; INC = 1; BusOut = 8'h70; step();
        total++; if (dout !== 8'h70) $display("FAIL wen_over_inc got=%h exp=70", dout); else passed++;
        BR = 1; Wen = 1; INC = 1; BusOut = 8'h10; step();
        total++; if (dout !== 8'h80) $display("FAIL br_over_wen got=%h exp=80", dout); else passed++;
        RST = 1; Wen = 1; BR = 1; BusOut = 8'h44; step();
        total++; if (dout !== 8'h00) $display("FAIL sync_rst got=%h exp=00", dout); else passed++;
    endtask

`ifdef PC_CALL_STACK_EN
    task automatic test_call_ret();
        load(8'h10);
        CALL = 1; BusOut = 8'h40; step();
        total++; if (dout !== 8'h40) $display("FAIL call_dout got=%h exp=40", dout); else passed++;
        total++; if (stk_empty !== 1'b0) $display("FAIL call_empty got=%b exp=0", stk_empty); else passed++;
        RET = 1; step();
        total++; if (dout !== 8'h11) $display("FAIL ret_dout got=%h exp=11", dout); else passed++;
        total++; if (stk_empty !== 1'b1) $display("FAIL ret_empty got=%b exp=1", stk_empty); else passed++;
    endtask

    task automatic test_full();
        load(8'h00);
        for (int i = 1; i <= 4; i++) begin
            CALL = 1; BusOut = 8'(i * 16); step();
        end
        total++; if (stk_full !== 1'b1) $display("FAIL full_flag got=%b exp=1", stk_full); else passed++;
        total++; if (dout !== 8'h40) $display("FAIL full_dout got=%h exp=40", dout); else passed++;
        CALL = 1; BusOut = 8'h99; step();
        total++; if (dout !== 8'h40) $display("FAIL overflow_dout got=%h exp=40", dout); else passed++;
        total++; if (stk_err !== 1'b1) $display("FAIL overflow_err got=%b exp=1", stk_err); else passed++;
        RET = 1; step();
        total++; if (dout !== 8'h31) $display("FAIL pop_after_full got=%h exp=31", dout); else passed++;
        total++; if (stk_err !== 1'b1) $display("FAIL err_sticky got=%b exp=1", stk_err); else passed++;
        RET = 1; step();
        total++; if (dout !== 8'h21) $display("FAIL pop2 got=%h exp=21", dout); else passed++;
        RST = 1; step();
        total++; if (dout !== 8'h00) $display("FAIL rst_dout got=%h exp=00", dout); else passed++;
        total++; if (stk_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", stk_err); else passed++;
        total++; if (stk_empty !== 1'b1) $display("FAIL rst_empty got=%b exp=1", stk_empty); else passed++;
    endtask

    task automatic test_empty_ret();
        load(8'h33);
        RET = 1; step();
        total++; if (dout !== 8'h33) $display("FAIL underflow_dout got=%h exp=33", dout); else passed++;
        total++; if (stk_err !== 1'b1) $display("FAIL underflow_err got=%b exp=1", stk_err); else passed++;
        CALL = 1; BusOut = 8'h50; step();
        RET = 1; INC = 1; step();
        total++; if (dout !== 8'h34) $display("FAIL ret_over_inc got=%h exp=34", dout); else passed++;
        total++; if (stk_empty !== 1'b1) $display("FAIL ret_over_inc_empty got=%b exp=1", stk_empty); else passed++;
    endtask
`else
    task automatic test_no_stack();
        load(8'h05);
        CALL = 1; BusOut = 8'h20; step();
        total++; if (dout !== 8'h20) $display("FAIL nostack_call got=%h exp=20", dout); else passed++;
        RET = 1; step();
        total++; if (dout !== 8'h20) $display("FAIL nostack_ret got=%h exp=20", dout); else passed++;
        total++; if (stk_empty !== 1'b1) $display("FAIL nostack_empty got=%b exp=1", stk_empty); else passed++;
        total++; if (stk_err !== 1'b0) $display("FAIL nostack_err got=%b exp=0", stk_err); else passed++;
        total++; if (stk_full !== 1'b0) $display("FAIL nostack_full got=%b exp=0", stk_full); else passed++;
        CALL = 1; BR = 1; BusOut = 8'h60; step();
        total++; if (dout !== 8'h60) $display("FAIL nostack_call_over_br got=%h exp=60", dout); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_inc();
        test_branch();
        test_priority();
`ifdef PC_CALL_STACK_EN
        test_call_ret();
        test_full();
        test_empty_ret();
`else
        test_no_stack();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
